kernel_launcher: RTL and testbench

- Host-side initiator for the start/ready/done accelerator handshake (the read_write_ram-style kernels).
- Per command: preloads N words into the shared RAM through its debug write port, waits for the kernel's ready, pulses start, and waits for done.
- After done, fetches one result word through the RAM debug read port and returns it to the requester.
- Sits between a host/command stream and one accelerator plus its RAM.

---
 rtl/kernel_launcher_pkg.sv | 21 ++
 rtl/kernel_launcher_if.sv | 59 +++++
 rtl/kernel_launcher_timeout_ctr.sv | 32 +++
 rtl/kernel_launcher.sv | 172 +++++++++++++++++
 tb/tb_kernel_launcher.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_launcher_pkg.sv
// Shared launcher state encoding and sizing helpers.
package kernel_launcher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_READY,
      ST_START,
      ST_RUN,
      ST_READBACK,
      ST_RESP
   } launch_state_t;

   localparam int TIMEOUT_DEF = 64;

   // Counter width able to hold every value 0..timeout.
   function automatic int timeout_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/kernel_launcher_if.sv
// Command, load, RAM debug, accelerator and result signals of one launcher.
// master is the launcher side; slave is the host/accelerator/RAM side.
interface kernel_launcher_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_base;
   logic [CNT_W-1:0]  cmd_count;
   logic [ADDR_W-1:0] cmd_res_addr;

   logic              ld_valid;
   logic              ld_ready;
   logic [DATA_W-1:0] ld_data;

   logic              dbg_write_en;
   logic [ADDR_W-1:0] dbg_write_addr;
   logic [DATA_W-1:0] dbg_write_data;
   logic [ADDR_W-1:0] dbg_read_addr;
   logic [DATA_W-1:0] dbg_read_data;

   logic              acc_start;
   logic              acc_ready;
   logic              acc_done;

   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic              res_timeout;

   modport master (
      input  cmd_valid, cmd_base, cmd_count, cmd_res_addr,
      output cmd_ready,
      input  ld_valid, ld_data,
      output ld_ready,
      output dbg_write_en, dbg_write_addr, dbg_write_data, dbg_read_addr,
      input  dbg_read_data,
      output acc_start,
      input  acc_ready, acc_done,
      output res_valid, res_data, res_timeout,
      input  res_ready
   );

   modport slave (
      output cmd_valid, cmd_base, cmd_count, cmd_res_addr,
      input  cmd_ready,
      output ld_valid, ld_data,
      input  ld_ready,
      input  dbg_write_en, dbg_write_addr, dbg_write_data, dbg_read_addr,
      output dbg_read_data,
      input  acc_start,
      output acc_ready, acc_done,
      input  res_valid, res_data, res_timeout,
      output res_ready
   );

endinterface

// File: rtl/kernel_launcher_timeout_ctr.sv
// Loadable up-counter with synchronous clear; expired flags count == LIMIT-1.
// Expired is combinational from the count; no backpressure.
module launch_timeout_ctr #(
   parameter int WIDTH = 7,
   parameter int LIMIT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

   assign expired = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/kernel_launcher.sv
// Preloads RAM words, runs one accelerator start/done handshake and returns one result word.
// Load and result paths are valid/ready; only WAIT_READY and RUN are bounded by TIMEOUT.
module kernel_launcher
   import kernel_launcher_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   kernel_launcher_if.master   bus
);

   localparam int TIMEOUT_W = timeout_w(TIMEOUT);

   launch_state_t     state_q;
   launch_state_t     state_d;

   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] res_addr_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  idx_q;
   logic              busy_seen_q;
   logic [DATA_W-1:0] res_data_q;
   logic              res_timeout_q;

   logic              tmo_clr;
   logic              tmo_en;
   logic              tmo_expired;
   logic              done_ok;
   logic              last_word;
   logic              abort;

   // A done is only trusted once the accelerator has been seen busy, which
   // filters out the level left over from the previous run.
   assign done_ok   = bus.acc_done && (busy_seen_q || !bus.acc_ready);
   assign last_word = (idx_q == count_q - CNT_W'(1));

   launch_timeout_ctr #(
      .WIDTH (TIMEOUT_W),
      .LIMIT (TIMEOUT)
   ) u_tmo (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmo_clr),
      .en       (tmo_en),
      .load     (1'b0),
      .load_val ({TIMEOUT_W{1'b0}}),
      .expired  (tmo_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmo_clr = 1'b0;
      tmo_en  = 1'b0;
      abort   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tmo_clr = 1'b1;
            if (bus.cmd_valid) begin
               state_d = (bus.cmd_count != '0) ? ST_LOAD : ST_WAIT_READY;
            end
         end
         ST_LOAD: begin
            if (bus.ld_valid && last_word) begin
               state_d = ST_WAIT_READY;
            end
         end
         ST_WAIT_READY: begin
            tmo_en = 1'b1;
            if (bus.acc_ready) begin
               tmo_clr = 1'b1;
               state_d = ST_START;
            end else if (tmo_expired) begin
               abort   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_START: begin
            tmo_clr = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            tmo_en = 1'b1;
            if (done_ok) begin
               state_d = ST_READBACK;
            end else if (tmo_expired) begin
               abort   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_READBACK: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q        <= '0;
         res_addr_q    <= '0;
         rd_addr_q     <= '0;
         count_q       <= '0;
         idx_q         <= '0;
         busy_seen_q   <= 1'b0;
         res_data_q    <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && bus.cmd_valid) begin
            base_q     <= bus.cmd_base;
            count_q    <= bus.cmd_count;
            res_addr_q <= bus.cmd_res_addr;
            idx_q      <= '0;
         end
         if (state_q == ST_LOAD && bus.ld_valid) begin
            idx_q <= idx_q + CNT_W'(1);
         end
         if (state_q == ST_START) begin
            busy_seen_q <= 1'b0;
         end
         if (state_q == ST_RUN && !bus.acc_ready) begin
            busy_seen_q <= 1'b1;
         end
         // Present the result address during READBACK; it then holds.
         if (state_q == ST_RUN && done_ok) begin
            rd_addr_q <= res_addr_q;
         end
         if (state_q == ST_READBACK) begin
            res_data_q    <= bus.dbg_read_data;
            res_timeout_q <= 1'b0;
         end
         if (abort) begin
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
         end
         if (state_q == ST_RESP && bus.res_ready) begin
            res_timeout_q <= 1'b0;
         end
      end
   end

   assign bus.cmd_ready      = (state_q == ST_IDLE);
   assign bus.ld_ready       = (state_q == ST_LOAD);
   assign bus.dbg_write_en   = (state_q == ST_LOAD) && bus.ld_valid;
   assign bus.dbg_write_addr = (state_q == ST_LOAD) ? base_q + ADDR_W'(idx_q) : '0;
   assign bus.dbg_write_data = (state_q == ST_LOAD) ? bus.ld_data : '0;
   assign bus.dbg_read_addr  = rd_addr_q;
   assign bus.acc_start      = (state_q == ST_START);
   assign bus.res_valid      = (state_q == ST_RESP);
   assign bus.res_data       = res_data_q;
   assign bus.res_timeout    = res_timeout_q;

endmodule

// File: tb/tb_kernel_launcher.sv
// Bench for kernel_launcher: RAM plus copy-kernel model, command table and result/write scoreboards.
module tb_kernel_launcher;

   typedef struct {
      logic [31:0] base;
      logic [7:0]  count;
      logic [31:0] res_addr;
      logic [31:0] d0;
      bit          gap;
      bit          early;
      bit          hang;
      int          delay;
      logic [31:0] exp_res;
      bit          exp_to;
      int          exp_starts;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [31:0] data;
      logic        to;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   kernel_launcher_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(8)) bus ();

   kernel_launcher #(
      .DATA_W  (32),
      .ADDR_W  (32),
      .CNT_W   (8),
      .TIMEOUT (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM and copy-kernel model: copies ram[acc_src] to ram[acc_dst] after a busy period.
   logic [31:0] ram [16];
   bit          ram_init    = 1'b0;
   logic        acc_ready_m = 1'b0;
   logic        acc_done_m  = 1'b0;
   int          phase       = 0;
   int          acnt        = 0;
   int          acc_lat     = 1;
   int          acc_busy    = 3;
   bit          acc_hang    = 1'b0;
   logic [3:0]  acc_src     = 4'd0;
   logic [3:0]  acc_dst     = 4'd0;

   assign bus.dbg_read_data = ram[bus.dbg_read_addr[3:0]];
   assign bus.acc_ready     = acc_ready_m;
   assign bus.acc_done      = acc_done_m;

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 16; i++) ram[i] <= 32'd0;
         ram_init <= 1'b1;
      end else if (bus.dbg_write_en) begin
         ram[bus.dbg_write_addr[3:0]] <= bus.dbg_write_data;
      end
      if (acc_hang) begin
         acc_ready_m <= 1'b0;
         phase       <= 0;
      end else begin
         case (phase)
            0: begin
               acc_ready_m <= 1'b1;
               if (bus.acc_start) begin
                  phase <= 1;
                  acnt  <= acc_lat;
               end
            end
            1: begin
               if (acnt <= 1) begin
                  acc_ready_m <= 1'b0;
                  acc_done_m  <= 1'b0;
                  phase       <= 2;
                  acnt        <= acc_busy;
               end else begin
                  acnt <= acnt - 1;
               end
            end
            default: begin
               if (acnt <= 1) begin
                  ram[acc_dst] <= ram[acc_src];
                  acc_ready_m  <= 1'b1;
                  acc_done_m   <= 1'b1;
                  phase        <= 0;
               end else begin
                  acnt <= acnt - 1;
               end
            end
         endcase
      end
   end

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_starts = 0;
   wr_t         wr_q[$];
   res_t        res_q[$];
   vec_t        vecs[5];
   logic        s_cmd_ready, s_ld_ready, s_res_valid, s_wr_en;
   logic [31:0] s_res_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expired_wait(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait bound expired, got no event, expected one", name);
   endtask

   // Sample outputs just after the falling edge, run the scoreboards, then advance one cycle.
   task automatic tick();
      wr_t  w;
      res_t r;
      #1;
      s_cmd_ready = bus.cmd_ready;
      s_ld_ready  = bus.ld_ready;
      s_res_valid = bus.res_valid;
      s_res_data  = bus.res_data;
      s_wr_en     = bus.dbg_write_en;
      if (bus.acc_start) n_starts++;
      if (bus.dbg_write_en) begin
         if (wr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got write to %h, expected none", bus.dbg_write_addr);
         end else begin
            w = wr_q.pop_front();
            chk("wr_addr", bus.dbg_write_addr, w.addr);
            chk("wr_data", bus.dbg_write_data, w.data);
         end
      end
      if (bus.res_valid && bus.res_ready) begin
         if (res_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got %h, expected none", bus.res_data);
         end else begin
            r = res_q.pop_front();
            chk("res_data", bus.res_data, r.data);
            chk("res_timeout", {31'd0, bus.res_timeout}, {31'd0, r.to});
         end
      end
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic [31:0] base, input logic [7:0] count,
                               input logic [31:0] res_addr, input logic [31:0] d0,
                               input bit gap, input bit early, input bit hang, input int delay,
                               input logic [31:0] exp_res, input bit exp_to, input int exp_starts);
      vec_t v;
      v.base = base; v.count = count; v.res_addr = res_addr; v.d0 = d0;
      v.gap = gap; v.early = early; v.hang = hang; v.delay = delay;
      v.exp_res = exp_res; v.exp_to = exp_to; v.exp_starts = exp_starts;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      wr_t  w;
      res_t r;
      bit   got;
      int   waits;
      int   starts0;
      starts0 = n_starts;
      acc_src = v.base[3:0];
      acc_dst = v.res_addr[3:0];
      r.data  = v.exp_res;
      r.to    = v.exp_to;
      res_q.push_back(r);
      bus.cmd_valid    = 1'b1;
      bus.cmd_base     = v.base;
      bus.cmd_count    = v.count;
      bus.cmd_res_addr = v.res_addr;
      if (v.early) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = v.d0;
         w.addr = v.base;
         w.data = v.d0;
         wr_q.push_back(w);
      end
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         tick();
         got = s_cmd_ready;
      end
      if (!got) expired_wait("cmd_accept");
      if (v.early) begin
         chk("idle_ld_not_taken", {31'd0, s_wr_en}, 32'd0);
         chk("idle_ld_ready", {31'd0, s_ld_ready}, 32'd0);
      end
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < int'(v.count); i++) begin
         if (v.gap && i > 0) begin
            bus.ld_valid = 1'b0;
            tick();
         end
         if (!(v.early && i == 0)) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = v.d0 + 32'(i);
            w.addr = v.base + 32'(i);
            w.data = v.d0 + 32'(i);
            wr_q.push_back(w);
         end
         got = 1'b0;
         for (int n = 0; n < 50 && !got; n++) begin
            tick();
            got = s_ld_ready;
         end
         if (!got) expired_wait("ld_accept");
         bus.ld_valid = 1'b0;
      end
      bus.res_ready = (v.delay == 0);
      got   = 1'b0;
      waits = 0;
      for (int n = 0; n < 300 && !got; n++) begin
         tick();
         if (s_res_valid) got = 1'b1;
         else waits++;
      end
      if (!got) expired_wait("res_valid");
      if (v.hang) chk("timeout_cycles", waits, 64);
      if (v.delay > 0) begin
         for (int d = 0; d < v.delay; d++) begin
            chk("bp_res_valid", {31'd0, s_res_valid}, 32'd1);
            chk("bp_cmd_ready", {31'd0, s_cmd_ready}, 32'd0);
            chk("bp_res_data", s_res_data, v.exp_res);
            tick();
         end
         bus.res_ready = 1'b1;
         tick();
      end
      bus.res_ready = 1'b0;
      tick();
      chk("back_to_idle", {31'd0, s_cmd_ready}, 32'd1);
      chk("res_cleared", {31'd0, s_res_valid}, 32'd0);
      chk("start_pulses", n_starts - starts0, v.exp_starts);
      chk("wr_q_drained", wr_q.size(), 0);
      chk("res_q_drained", res_q.size(), 0);
   endtask

   initial begin
      bit got;
      int starts0;
      vecs[0] = mk(32'd10,         8'd1, 32'd12, 32'd15,   0, 1, 0, 5, 32'd15,   0, 1);
      vecs[1] = mk(32'hFFFF_FFFE,  8'd4, 32'd3,  32'hA0,   1, 0, 0, 0, 32'hA0,   0, 1);
      vecs[2] = mk(32'd10,         8'd0, 32'd5,  32'd0,    0, 0, 0, 0, 32'd15,   0, 1);
      vecs[3] = mk(32'd20,         8'd1, 32'd6,  32'h55,   0, 0, 0, 2, 32'h55,   0, 1);
      vecs[4] = mk(32'd0,          8'd0, 32'd0,  32'd0,    0, 0, 1, 0, 32'd0,    1, 0);

      bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_count = '0; bus.cmd_res_addr = '0;
      bus.ld_valid = 1'b0; bus.ld_data = '0; bus.res_ready = 1'b0;

      #2 rst = 1'b0;
      #1;
      chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
      chk("rst_wr_en", {31'd0, bus.dbg_write_en}, 32'd0);
      chk("rst_acc_start", {31'd0, bus.acc_start}, 32'd0);
      chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("rst_res_data", bus.res_data, 32'd0);
      chk("rst_rd_addr", bus.dbg_read_addr, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();

      for (int k = 0; k < 5; k++) begin
         acc_hang = vecs[k].hang;
         tick();
         tick();
         run_vec(vecs[k]);
      end
      acc_hang = 1'b0;
      tick();
      tick();

      // Reset during RUN: no response, outputs return to their reset values at once.
      acc_busy = 20;
      starts0  = n_starts;
      bus.cmd_valid = 1'b1; bus.cmd_base = 32'd0; bus.cmd_count = 8'd0; bus.cmd_res_addr = 32'd9;
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         tick();
         got = s_cmd_ready;
      end
      if (!got) expired_wait("rst_cmd_accept");
      bus.cmd_valid = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         tick();
         got = (n_starts != starts0);
      end
      if (!got) expired_wait("rst_start");
      tick();
      tick();
      chk("run_not_idle", {31'd0, s_cmd_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("midrst_acc_start", {31'd0, bus.acc_start}, 32'd0);
      chk("midrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("midrst_res_timeout", {31'd0, bus.res_timeout}, 32'd0);
      chk("midrst_rd_addr", bus.dbg_read_addr, 32'd0);
      chk("midrst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      bus.res_ready = 1'b1;
      for (int n = 0; n < 30; n++) tick();
      chk("midrst_no_response", {31'd0, s_res_valid}, 32'd0);
      chk("midrst_idle", {31'd0, s_cmd_ready}, 32'd1);
      chk("final_res_q", res_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
